led_pattern_bank: RTL and testbench



---
 rtl/led_pattern_bank.sv | 127 ++++++++++++
 tb/tb_led_pattern_bank.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_bank.sv
// Bank of NCH independent LED pattern generators (off/on/toggle/PWM/pulse).
// Each channel has its own period, duty and mode, plus a global phase-sync strobe.
module led_pattern_bank #(
    parameter int NCH        = 8,
    parameter int CW         = 27,
    parameter int DEF_PERIOD = 50000000,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cfg_write,
    input  logic [CHW-1:0]   cfg_chan,
    input  logic [2:0]       cfg_mode,
    input  logic [CW-1:0]    cfg_period,
    input  logic [CW-1:0]    cfg_duty,
    input  logic             sync,
    output logic [NCH-1:0]   led,
    output logic [NCH-1:0]   wrap
);

    localparam logic [2:0] M_OFF    = 3'd0;
    localparam logic [2:0] M_ON     = 3'd1;
    localparam logic [2:0] M_TOGGLE = 3'd2;
    localparam logic [2:0] M_PWM    = 3'd3;
    localparam logic [2:0] M_PULSE  = 3'd4;

    localparam logic [CW-1:0]  ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0]  ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  DEF_PER  = CW'(DEF_PERIOD);
    localparam logic [CW-1:0]  DEF_DUTY = CW'(DEF_PERIOD / 2);
    localparam logic [CHW:0]   NCH_L    = (CHW + 1)'(NCH);

    // LED level on the first cycle after a restart (config write or sync).
    function automatic logic restart_led(input logic [2:0] m, input logic [CW-1:0] d);
        return (m == M_ON) || ((m == M_PWM) && (d != ZERO));
    endfunction

    logic wr_ok_s;
    assign wr_ok_s = cfg_write && ({1'b0, cfg_chan} < NCH_L);

    logic [NCH-1:0] led_q;
    logic [NCH-1:0] wrap_q;
    assign led  = led_q;
    assign wrap = wrap_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [2:0]    mode_q, mode_d;
        logic [CW-1:0] per_q, per_d;
        logic [CW-1:0] duty_q, duty_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          led_d, wrap_d;
        logic [CW-1:0] pe_s;
        logic          term_s;
        logic          counting_s;
        logic [CW-1:0] cnt_run_s;
        logic          led_run_s;
        logic          hit_s;

        assign hit_s      = wr_ok_s && (cfg_chan == CHW'(i));
        assign pe_s       = (per_q == ZERO) ? ONE : per_q;
        assign term_s     = (cnt_q == (pe_s - ONE));
        assign counting_s = (mode_q == M_TOGGLE) || (mode_q == M_PWM) || (mode_q == M_PULSE);

        // Free-running pattern step for the current mode.
        always_comb begin
            cnt_run_s = ZERO;
            led_run_s = 1'b0;
            if (counting_s) begin
                cnt_run_s = term_s ? ZERO : (cnt_q + ONE);
            end else begin
                cnt_run_s = ZERO;
            end
            case (mode_q)
                M_OFF:    led_run_s = 1'b0;
                M_ON:     led_run_s = 1'b1;
                M_TOGGLE: led_run_s = led_q[i] ^ term_s;
                M_PWM:    led_run_s = (cnt_run_s < duty_q);
                M_PULSE:  led_run_s = term_s;
                default:  led_run_s = 1'b0;
            endcase
        end

        // Next state: a write to this channel wins over sync, sync over running.
        always_comb begin
            mode_d = mode_q;
            per_d  = per_q;
            duty_d = duty_q;
            cnt_d  = cnt_run_s;
            led_d  = led_run_s;
            wrap_d = counting_s && term_s;
            if (hit_s) begin
                mode_d = cfg_mode;
                per_d  = cfg_period;
                duty_d = cfg_duty;
                cnt_d  = ZERO;
                wrap_d = 1'b0;
                led_d  = restart_led(cfg_mode, cfg_duty);
            end else if (sync) begin
                cnt_d  = ZERO;
                wrap_d = 1'b0;
                led_d  = restart_led(mode_q, duty_q);
            end else begin
                cnt_d  = cnt_run_s;
            end
        end

        // Channel state register with asynchronous reset to the default toggle.
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                mode_q    <= M_TOGGLE;
                per_q     <= DEF_PER;
                duty_q    <= DEF_DUTY;
                cnt_q     <= ZERO;
                led_q[i]  <= 1'b0;
                wrap_q[i] <= 1'b0;
            end else begin
                mode_q    <= mode_d;
                per_q     <= per_d;
                duty_q    <= duty_d;
                cnt_q     <= cnt_d;
                led_q[i]  <= led_d;
                wrap_q[i] <= wrap_d;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_bank.sv
// Randomised scoreboard bench for led_pattern_bank against a phase-based pattern model.
module tb_led_pattern_bank;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DEF = 4;
    localparam int CHW = 2;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic            cfg_write;
    logic [CHW-1:0]  cfg_chan;
    logic [2:0]      cfg_mode;
    logic [CW-1:0]   cfg_period;
    logic [CW-1:0]   cfg_duty;
    logic            sync;
    logic [NCH-1:0]  led;
    logic [NCH-1:0]  wrap;

    led_pattern_bank #(.NCH(NCH), .CW(CW), .DEF_PERIOD(DEF)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_write(cfg_write), .cfg_chan(cfg_chan),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty), .sync(sync),
        .led(led), .wrap(wrap)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [NCH-1:0] led;
        logic [NCH-1:0] wrap;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Model: each channel is described by where it sits inside its period.
    int m_mode  [NCH];
    int m_per   [NCH];
    int m_duty  [NCH];
    int m_phase [NCH];
    bit m_fresh [NCH];
    bit m_tog   [NCH];

    function automatic bit counting(int c);
        return m_mode[c] == 2 || m_mode[c] == 3 || m_mode[c] == 4;
    endfunction

    function automatic void restart(int c);
        m_phase[c] = 0;
        m_fresh[c] = 1'b1;
        m_tog[c]   = 1'b0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 2;
            m_per[c]  = DEF;
            m_duty[c] = DEF / 2;
            restart(c);
        end
    endfunction

    function automatic void model_step(bit wr, int ch, int md, int pr, int dt, bit sy);
        for (int c = 0; c < NCH; c++) begin
            if (wr && ch < NCH && c == ch) begin
                m_mode[c] = md; m_per[c] = pr; m_duty[c] = dt;
                restart(c);
            end else if (sy) begin
                restart(c);
            end else if (counting(c)) begin
                m_phase[c] = (m_phase[c] + 1) % ((m_per[c] == 0) ? 1 : m_per[c]);
                if (m_phase[c] == 0) begin
                    m_fresh[c] = 1'b0;
                    m_tog[c]   = ~m_tog[c];
                end
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            bit w;
            w = counting(c) && !m_fresh[c] && m_phase[c] == 0;
            e.wrap[c] = w;
            case (m_mode[c])
                1: e.led[c] = 1'b1;
                2: e.led[c] = m_tog[c];
                3: e.led[c] = (m_phase[c] < m_duty[c]);
                4: e.led[c] = w;
                default: e.led[c] = 1'b0;
            endcase
        end
        return e;
    endfunction

    // Monitor: compare every presented output cycle against the scoreboard head.
    always @(negedge sys_clk) begin
        if (!sys_rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (led !== e.led) begin
                errors++;
                $display("FAIL led @%0t: got %b expected %b", $time, led, e.led);
            end
            checks++;
            if (wrap !== e.wrap) begin
                errors++;
                $display("FAIL wrap @%0t: got %b expected %b", $time, wrap, e.wrap);
            end
        end
    end

    task automatic cyc(input bit wr, input int ch, input int md, input int pr, input int dt,
                       input bit sy);
        cfg_write  = wr;
        cfg_chan   = CHW'(ch);
        cfg_mode   = 3'(md);
        cfg_period = CW'(pr);
        cfg_duty   = CW'(dt);
        sync       = sy;
        @(posedge sys_clk);
        model_step(wr, ch, md, pr, dt, sy);
        exp_q.push_back(model_out());
        #1;
        cfg_write = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (led !== '0 || wrap !== '0) begin
            errors++;
            $display("FAIL %s: led=%b wrap=%b expected 0/0", name, led, wrap);
        end
    endtask

    initial begin
        sys_rst = 1'b1; cfg_write = 1'b0; cfg_chan = '0; cfg_mode = '0;
        cfg_period = '0; cfg_duty = '0; sync = 1'b0;
        #2;
        check_zero("reset_initial");
        @(posedge sys_clk);
        #1;
        check_zero("reset_held");
        release_reset();
        idle(20);

        cyc(1'b1, 1, 3, 5, 2, 1'b0);
        idle(12);
        cyc(1'b1, 0, 3, 5, 0, 1'b0);
        idle(8);
        cyc(1'b1, 0, 3, 5, 7, 1'b0);
        idle(8);
        cyc(1'b1, 0, 2, 0, 0, 1'b0);
        idle(6);
        cyc(1'b1, 0, 4, 3, 0, 1'b0);
        idle(9);
        cyc(1'b1, 3, 1, 1, 1, 1'b0);
        idle(6);
        cyc(1'b1, 2, 2, 6, 0, 1'b0);
        idle(4);
        cyc(1'b1, 1, 1, 9, 0, 1'b1);
        idle(5);

        @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        exp_q.delete();
        #1;
        check_zero("reset_async");
        release_reset();
        idle(10);

        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(0, 5) == 0), $urandom_range(0, 3), $urandom_range(0, 7),
                $urandom_range(0, 9), $urandom_range(0, 11), ($urandom_range(0, 19) == 0));
        end
        idle(2);
        @(negedge sys_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
